// File: rtl/cordic_angle_reduce.sv
// -----------------------------------------------------------------------------
// cordic_angle_reduce
//
// Range-reduction front end for the CORDIC core. A signed Q16.16 angle in
// radians is reduced modulo 2*pi by binary long division. Division steps run
// from 2*pi<<(STEPS-1) down to 2*pi<<0. The 0..2*pi result is then folded into
// [-pi/2, pi/2]. When the fold went through the pi offset, flip is raised so
// that the consumer negates both sin and cos.
//
// Ports:
//   clk        in   rising-edge clock
//   reset      in   synchronous, active-high; aborts any operation
//   start      in   request; only honoured while idle
//   angle_in   in   signed Q16.16 angle, captured on the accepting edge
//   angle_out  out  reduced signed Q16.16 angle, in [-HALF_PI, HALF_PI)
//   flip       out  1 = consumer negates both sin and cos
//   quad       out  quadrant of the 0..2*pi reduced angle
//   busy       out  high while an operation is in flight
//   done       out  one-cycle pulse; outputs are valid from this cycle on
// -----------------------------------------------------------------------------
module cordic_angle_reduce #(
    parameter int TWO_PI        = 411775,
    parameter int PI            = 205887,
    parameter int HALF_PI       = 102944,
    parameter int THREE_HALF_PI = 308831,
    parameter int STEPS         = 13
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic signed [31:0] angle_in,
    output logic signed [31:0] angle_out,
    output logic               flip,
    output logic [1:0]         quad,
    output logic               busy,
    output logic               done
);

    localparam int KW = (STEPS > 1) ? $clog2(STEPS) : 1;

    localparam logic [32:0]   TWO_PI_W   = 33'(TWO_PI);
    localparam logic [32:0]   STEP_INIT  = TWO_PI_W << (STEPS - 1);
    localparam logic [KW-1:0] K_INIT     = KW'(STEPS - 1);

    localparam logic [31:0] TWO_PI_32        = 32'(TWO_PI);
    localparam logic [31:0] PI_32            = 32'(PI);
    localparam logic [31:0] HALF_PI_32       = 32'(HALF_PI);
    localparam logic [31:0] THREE_HALF_PI_32 = 32'(THREE_HALF_PI);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REDUCE,
        S_WRAP,
        S_MAP
    } state_t;

    state_t             state_q, state_d;
    logic               neg_q, neg_d;
    logic [32:0]        mag_q, mag_d;
    logic [32:0]        step_q, step_d;
    logic [KW-1:0]      k_q, k_d;
    logic [31:0]        a_q, a_d;
    logic signed [31:0] angle_out_q, angle_out_d;
    logic               flip_q, flip_d;
    logic [1:0]         quad_q, quad_d;
    logic               done_q, done_d;

    // 33-bit sign extension, so that the magnitude of -2^31 is representable.
    logic [32:0] angle_ext;
    assign angle_ext = {angle_in[31], angle_in};

    always_comb begin
        state_d     = state_q;
        neg_d       = neg_q;
        mag_d       = mag_q;
        step_d      = step_q;
        k_d         = k_q;
        a_d         = a_q;
        angle_out_d = angle_out_q;
        flip_d      = flip_q;
        quad_d      = quad_q;
        done_d      = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    neg_d   = angle_in[31];
                    mag_d   = angle_in[31] ? (~angle_ext + 33'd1) : angle_ext;
                    step_d  = STEP_INIT;
                    k_d     = K_INIT;
                    state_d = S_REDUCE;
                end
            end

            S_REDUCE: begin
                // Restoring division step. Only the remainder is kept.
                if (mag_q >= step_q) begin
                    mag_d = mag_q - step_q;
                end
                step_d = step_q >> 1;
                if (k_q == '0) begin
                    state_d = S_WRAP;
                end else begin
                    k_d = k_q - 1'b1;
                end
            end

            S_WRAP: begin
                // At this point mag < 2*pi, so both results fit in 32 bits.
                // A negative input maps to 2*pi - |x| mod 2*pi. An exact
                // multiple of 2*pi stays at 0 rather than becoming 2*pi.
                if (neg_q && (mag_q != '0)) begin
                    a_d = 32'(TWO_PI_W - mag_q);
                end else begin
                    a_d = 32'(mag_q);
                end
                state_d = S_MAP;
            end

            S_MAP: begin
                if (a_q < HALF_PI_32) begin
                    angle_out_d = $signed(a_q);
                    flip_d      = 1'b0;
                end else if (a_q < THREE_HALF_PI_32) begin
                    angle_out_d = $signed(a_q - PI_32);
                    flip_d      = 1'b1;
                end else begin
                    angle_out_d = $signed(a_q - TWO_PI_32);
                    flip_d      = 1'b0;
                end

                if (a_q < HALF_PI_32) begin
                    quad_d = 2'd0;
                end else if (a_q < PI_32) begin
                    quad_d = 2'd1;
                end else if (a_q < THREE_HALF_PI_32) begin
                    quad_d = 2'd2;
                end else begin
                    quad_d = 2'd3;
                end

                done_d  = 1'b1;
                state_d = S_IDLE;
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            neg_q       <= 1'b0;
            mag_q       <= '0;
            step_q      <= '0;
            k_q         <= '0;
            a_q         <= '0;
            angle_out_q <= '0;
            flip_q      <= 1'b0;
            quad_q      <= 2'd0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            neg_q       <= neg_d;
            mag_q       <= mag_d;
            step_q      <= step_d;
            k_q         <= k_d;
            a_q         <= a_d;
            angle_out_q <= angle_out_d;
            flip_q      <= flip_d;
            quad_q      <= quad_d;
            done_q      <= done_d;
        end
    end

    assign angle_out = angle_out_q;
    assign flip      = flip_q;
    assign quad      = quad_q;
    assign done      = done_q;
    assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_cordic_angle_reduce.sv
module tb_cordic_angle_reduce;

    localparam longint TWO_PI_M  = 411775;
    localparam longint PI_M      = 205887;
    localparam longint HALF_PI_M = 102944;
    localparam longint THP_M     = 308831;

    logic               clk = 1'b0;
    logic               reset;
    logic               start;
    logic signed [31:0] angle_in;
    logic signed [31:0] angle_out;
    logic               flip;
    logic [1:0]         quad;
    logic               busy;
    logic               done;

    cordic_angle_reduce dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .angle_in  (angle_in),
        .angle_out (angle_out),
        .flip      (flip),
        .quad      (quad),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0]        src;
        logic signed [31:0] ang;
        logic               flp;
        logic [1:0]         qd;
        int                 acc;
    } exp_t;

    exp_t sb[$];
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference: true modulo arithmetic on wide integers, then the fold.
    function automatic exp_t model(input logic [31:0] x, input int acc);
        exp_t   e;
        longint m;
        longint r;
        longint a;
        bit     neg;
        m   = longint'($signed(x));
        neg = (m < 0);
        if (neg) m = -m;
        r = m % TWO_PI_M;
        a = (neg && r != 0) ? (TWO_PI_M - r) : r;
        if (a < HALF_PI_M) begin
            e.ang = 32'(a);
            e.flp = 1'b0;
        end else if (a < THP_M) begin
            e.ang = 32'(a - PI_M);
            e.flp = 1'b1;
        end else begin
            e.ang = 32'(a - TWO_PI_M);
            e.flp = 1'b0;
        end
        e.qd  = (a < HALF_PI_M) ? 2'd0 : (a < PI_M) ? 2'd1 : (a < THP_M) ? 2'd2 : 2'd3;
        e.src = x;
        e.acc = acc;
        return e;
    endfunction

    task automatic check(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding request.
    always @(negedge clk) begin
        if (done) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check($sformatf("angle_out[%h]", e.src), angle_out, e.ang);
                check($sformatf("flip[%h]", e.src), flip, e.flp);
                check($sformatf("quad[%h]", e.src), quad, e.qd);
                check($sformatf("latency[%h]", e.src), cyc - e.acc, 15);
                check($sformatf("busy_at_done[%h]", e.src), busy, 0);
            end
        end
    end

    // Issues one request. On return, the next negedge is the done cycle,
    // so the following issue starts back-to-back.
    task automatic issue(input logic [31:0] x);
        @(negedge clk);
        start    = 1'b1;
        angle_in = x;
        @(negedge clk);
        start = 1'b0;
        sb.push_back(model(x, cyc));
        check("busy_after_accept", busy, 1);
        for (int i = 1; i < 15; i++) begin
            @(negedge clk);
            check("busy_inflight", busy, 1);
            check("done_early", done, 0);
        end
    endtask

    initial begin
        reset    = 1'b1;
        start    = 1'b0;
        angle_in = '0;
        repeat (3) @(negedge clk);
        check("rst_angle_out", angle_out, 0);
        check("rst_flip", flip, 0);
        check("rst_quad", quad, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        reset = 1'b0;

        issue(32'd0);
        issue(32'd102944);
        issue(32'd205887);
        issue(32'd856318);
        issue(32'hFFFF_36F0);   // -51472
        issue(32'h8000_0000);
        issue(32'h7FFF_FFFF);
        issue(32'd411775);
        issue(32'hFFF9_B781);   // -411775
        issue(32'd308831);
        issue(32'd308830);
        issue(32'd102943);

        for (int n = 0; n < 40; n++) begin
            issue($urandom);
        end

        // start re-pulsed mid-operation with another angle: ignored.
        @(negedge clk);
        start    = 1'b1;
        angle_in = 32'd60000;
        @(negedge clk);
        start = 1'b0;
        sb.push_back(model(32'd60000, cyc));
        for (int i = 1; i < 15; i++) begin
            @(negedge clk);
            if (i == 3 || i == 10) begin
                start    = 1'b1;
                angle_in = 32'd250000;
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;

        // start held high through done: the second request is accepted.
        @(negedge clk);
        start    = 1'b1;
        angle_in = 32'd150000;
        @(negedge clk);
        sb.push_back(model(32'd150000, cyc));
        angle_in = 32'hFFFE_0000;
        repeat (16) @(negedge clk);
        start = 1'b0;
        sb.push_back(model(32'hFFFE_0000, cyc));
        repeat (16) @(negedge clk);

        // reset mid-operation: aborts, no done for the aborted request.
        start    = 1'b1;
        angle_in = 32'd300000;
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);
        reset = 1'b1;
        start = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        start = 1'b0;
        check("abort_angle_out", angle_out, 0);
        check("abort_flip", flip, 0);
        check("abort_quad", quad, 0);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        repeat (20) @(negedge clk);

        issue(32'd51472);
        repeat (4) @(negedge clk);

        check("scoreboard_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cordic_angle_reduce.md
# cordic_angle_reduce

Sequential range-reduction stage that sits directly upstream of the `cordic` core. It accepts an arbitrary signed Q16.16 angle in radians and reduces it modulo 2π. It then folds the result into [−π/2, π/2], which lies inside the CORDIC convergence range, and flags when the downstream sin/cos results must both be negated. `angle_out` drives `cordic.angle`, `done` drives `cordic.enable`, and `flip` is applied by the consumer to `sin_out`/`cos_out`.

## Interface

Parameters:
- `TWO_PI`, default 411775: 2π in Q16.16.
- `PI`, default 205887: π in Q16.16.
- `HALF_PI`, default 102944: π/2 in Q16.16.
- `THREE_HALF_PI`, default 308831: 3π/2 in Q16.16.
- `STEPS`, default 13: reduction iterations, covering k = 12..0.

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  synchronous, active-high.
- `start`  in  1  request; sampled only in IDLE.
- `angle_in`  in  32  signed Q16.16 angle, captured on the accepting edge.
- `angle_out`  out  32  signed Q16.16 reduced angle, in [−102944, 102943].
- `flip`  out  1  1 means the consumer negates both sin and cos.
- `quad`  out  2  quadrant of the 0..2π-reduced angle.
- `busy`  out  1  high while state ≠ IDLE.
- `done`  out  1  one-cycle pulse; outputs valid from this cycle onward.

## Operation

- States: IDLE, REDUCE, WRAP, MAP.
- IDLE:
  - On `start`, capture `neg = angle_in[31]` and the magnitude `|angle_in|` as a 33-bit unsigned value (−2^31 gives 2^31, with no overflow).
  - Load the shifted constant `TWO_PI << 12` and set `k = 12`.
  - Go to REDUCE.
- REDUCE, one step per cycle for k = 12 down to 0:
  - If `mag ≥ TWO_PI << k`, then `mag -= TWO_PI << k`.
  - After the k = 0 step, go to WRAP. At that point `mag < TWO_PI`.
- WRAP:
  - If `neg` and `mag ≠ 0`, then `a = TWO_PI − mag`; otherwise `a = mag`.
  - Go to MAP.
- MAP:
  - `a < HALF_PI`: `angle_out = a`, `flip = 0`.
  - `a < THREE_HALF_PI`: `angle_out = a − PI`, `flip = 1`.
  - Otherwise: `angle_out = a − TWO_PI`, `flip = 0`.
  - `quad`: 0 if `a < HALF_PI`, 1 if `a < PI`, 2 if `a < THREE_HALF_PI`, else 3.
  - Assert `done` and return to IDLE.
- Output behaviour:
  - `angle_out`, `flip` and `quad` update only in MAP and hold until the next MAP.
- Boundaries:
  - Inputs exactly on a boundary fall into the upper region, using strict `<` compares.
- Arithmetic:
  - All compares are unsigned on 33 bits until MAP.
  - MAP results are sign-extended to 32 bits.
  - No rounding or saturation is needed.

## Timing

- Reset value of every output: `angle_out = 0`, `flip = 0`, `quad = 0`, `busy = 0`, `done = 0`. State returns to IDLE.
- Latency: the edge that accepts `start` is edge 0.
  - REDUCE runs on edges 1–13, WRAP on edge 14, MAP on edge 15.
  - `done` is high for exactly the cycle following edge 15.
  - Fixed 15-cycle latency, independent of input value.
- `busy` rises after edge 0 and falls after edge 15, in the same cycle `done` is high.
- `start` while `busy`: ignored; no queuing, and the in-flight result is unaffected.
- `start` in the cycle `done` is high: accepted, because the state is IDLE. Back-to-back throughput is one result per 16 cycles.
- `reset` asserted mid-operation (any state):
  - Aborts the operation; the next edge forces IDLE and clears all outputs.
  - No `done` is produced for the aborted request.
- `reset` and `start` high together: reset wins.

## Test plan

- `angle_in = 0`, `start` pulse → `done` exactly 15 cycles later; `angle_out = 0`, `flip = 0`, `quad = 0`; `busy` high for 15 cycles.
- `angle_in = 102944` (π/2) → `angle_out = −102943`, `flip = 1`, `quad = 1`. `angle_in = 205887` (π) → `angle_out = 0`, `flip = 1`, `quad = 2`.
- `angle_in = 856318` (4π + 0.5) → `angle_out = 32768`, `flip = 0`, `quad = 0`. `angle_in = −51472` (−π/4) → `angle_out = −51472`, `flip = 0`, `quad = 3`.
- `angle_in = 0x80000000` → `angle_out = −77023`, `flip = 0`, `quad = 3`. `angle_in = 0x7FFFFFFF` → result checked against a software model of the same algorithm.
- `start` re-pulsed at cycles 3 and 10 of an operation with a different angle → ignored; the original result is delivered. `start` held high through `done` → second operation accepted, and its `done` arrives 16 cycles after the first.
- `reset` pulsed at cycle 7 of an operation → all outputs 0 and `busy = 0` after the edge; no `done` pulse. A following `start` with `angle_in = 51472` → `angle_out = 51472`, `flip = 0`, 15 cycles later.
